// File: rtl/button_control.sv
// Run/stop controller: synchronises the start/pause and finish buttons, detects
// press edges and holds the registered run level in a two-state machine.
module button_control #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic buttonSt,
    input  logic buttonFi,
    output logic run
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] st_sync;
    logic [SYNC_STAGES-1:0] fi_sync;
    logic                   st_prev;
    logic                   fi_prev;
    logic [2:0]             fill_cnt;
    logic                   filled;
    logic                   st_edge;
    logic                   fi_edge;
    state_t                 state;
    state_t                 state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            st_sync  <= '0;
            fi_sync  <= '0;
            st_prev  <= 1'b0;
            fi_prev  <= 1'b0;
            fill_cnt <= '0;
        end else begin
            st_sync <= {st_sync[SYNC_STAGES-2:0], buttonSt};
            fi_sync <= {fi_sync[SYNC_STAGES-2:0], buttonFi};
            st_prev <= st_sync[SYNC_STAGES-1];
            fi_prev <= fi_sync[SYNC_STAGES-1];
            if (fill_cnt != FILL_DONE) begin
                fill_cnt <= fill_cnt + 3'd1;
            end
        end
    end

    // The chains restart from zero after reset, so a button held through reset
    // would look like a fresh rising edge while they refill; edges are ignored
    // until the chain and previous flop again reflect the real button level.
    assign filled  = (fill_cnt == FILL_DONE);
    assign st_edge = filled & st_sync[SYNC_STAGES-1] & ~st_prev;
    assign fi_edge = filled & fi_sync[SYNC_STAGES-1] & ~fi_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= STOPPED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (fi_edge) begin
            state_next = STOPPED;
        end else if (st_edge) begin
            state_next = (state == STOPPED) ? RUNNING : STOPPED;
        end
    end

    always_comb begin
        run = (state == RUNNING);
    end

endmodule

// File: tb/tb_button_control.sv
// Directed bench for button_control: each step drives the buttons across one
// rising edge and checks run against a hand-computed value on the falling edge.
module tb_button_control;

    logic clock;
    logic reset;
    logic buttonSt;
    logic buttonFi;
    logic run;

    int unsigned checks;
    int unsigned errors;

    button_control #(
        .SYNC_STAGES(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .buttonSt (buttonSt),
        .buttonFi (buttonFi),
        .run      (run)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic st, input logic fi, input logic exp, input string tag);
        buttonSt = st;
        buttonFi = fi;
        @(negedge clock);
        checks++;
        assert (run === exp) else begin
            errors++;
            $error("FAIL %s (check %0d): run=%b expected %b", tag, checks, run, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        buttonSt = 1'b0;
        buttonFi = 1'b0;

        // reset with both buttons low, then idle
        step(0, 0, 0, "reset");
        reset = 1'b0;
        repeat (5) step(0, 0, 0, "reset_idle");

        // long start press toggles once, then a 2-cycle press toggles back
        step(1, 0, 0, "st1_lat0");
        step(1, 0, 0, "st1_lat1");
        repeat (4) step(1, 0, 1, "st1_held");
        repeat (3) step(0, 0, 1, "st1_release");
        step(1, 0, 1, "st2_lat0");
        step(1, 0, 1, "st2_lat1");
        repeat (3) step(0, 0, 0, "st2_stopped");

        // finish while running, then finish again while stopped
        step(1, 0, 0, "st3_lat0");
        step(0, 0, 0, "st3_lat1");
        repeat (3) step(0, 0, 1, "st3_running");
        step(0, 1, 1, "fi1_lat0");
        step(0, 0, 1, "fi1_lat1");
        repeat (3) step(0, 0, 0, "fi1_stopped");
        step(0, 1, 0, "fi2_lat0");
        repeat (3) step(0, 0, 0, "fi2_stays");

        // resume after finish, then Fi, Fi, St with 1-cycle gaps
        step(1, 0, 0, "resume_lat0");
        step(0, 0, 0, "resume_lat1");
        step(0, 0, 1, "resume_run");
        step(0, 0, 1, "resume_hold");
        step(0, 1, 1, "seq_fi_a");
        step(0, 0, 1, "seq_gap_a");
        step(0, 1, 0, "seq_fi_b");
        step(0, 0, 0, "seq_gap_b");
        step(1, 0, 0, "seq_st");
        step(0, 0, 0, "seq_gap_c");
        step(0, 0, 1, "seq_run");
        step(0, 0, 1, "seq_run_hold");

        // simultaneous presses from RUNNING, then from STOPPED
        step(1, 1, 1, "both_run_lat0");
        step(0, 0, 1, "both_run_lat1");
        repeat (4) step(0, 0, 0, "both_run_stopped");
        step(1, 1, 0, "both_stop_lat0");
        repeat (4) step(0, 0, 0, "both_stop_stays");

        // start edge at k, finish edge at k+1: one cycle of run
        step(1, 0, 0, "stfi_st");
        step(0, 1, 0, "stfi_fi");
        step(0, 0, 1, "stfi_pulse");
        step(0, 0, 0, "stfi_stopped");
        step(0, 0, 0, "stfi_stays");

        // reset mid-run with start held, held press ignored afterwards
        step(1, 0, 0, "mid_lat0");
        step(0, 0, 0, "mid_lat1");
        step(0, 0, 1, "mid_running");
        step(0, 0, 1, "mid_running_hold");
        reset = 1'b1;
        step(1, 0, 0, "mid_reset");
        reset = 1'b0;
        repeat (6) step(1, 0, 0, "mid_held_ignored");
        repeat (3) step(0, 0, 0, "mid_released");
        step(1, 0, 0, "mid_repress_lat0");
        step(0, 0, 0, "mid_repress_lat1");
        step(0, 0, 1, "mid_repress_run");
        step(0, 0, 1, "mid_repress_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
